// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared defaults and FSM state type for the two-port RAM
//               burst arbiter (ram_arbiter, rr_arb2).
//               Contents:
//                 c_ADDR_W / c_DATA_W / c_LEN_W - default widths
//                 state_t                       - IDLE / XFER / DONE
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

   localparam int c_ADDR_W = 12;
   localparam int c_DATA_W = 8;
   localparam int c_LEN_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin selector, purely combinational.
//               Ports:
//                 req[1:0] in  - request lines
//                 last     in  - index of the requester served last
//                 sel      out - selected requester index
//                 any      out - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       sel,
   output logic       any
);

   assign any = |req;

   // On contention the requester not served last wins; otherwise the sole
   // requester (sel is meaningless when any=0).
   assign sel = (&req) ? ~last : req[1];

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Arbitrates burst read/write transactions from two requesters
//               onto one external combinational-read RAM, round-robin.
//               Ports:
//                 clock, rstn         - clock, async active-low reset
//                 req/rw/addr/len     - per-requester transaction request
//                 wdata               - per-requester current write beat
//                 gnt, wr_ack, done   - per-requester handshake pulses
//                 rd_valid, rd_data   - registered read beat (shared data)
//                 ram_*               - external RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W,
   parameter int LEN_W  = c_LEN_W
) (
   input  logic                clock,
   input  logic                rstn,
   input  logic [1:0]          req,
   input  logic [1:0]          rw,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*LEN_W-1:0]  len,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          wr_ack,
   output logic [1:0]          rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic [1:0]          done,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W-1:0]   ram_data_in,
   output logic                ram_wren,
   input  logic [DATA_W-1:0]   ram_data_out
);

   state_t              r_state;
   state_t              w_next;
   logic                r_sel;
   logic                r_last;
   logic                r_rw;
   logic                r_first;
   logic                r_rd_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rd_data;

   logic                w_sel;
   logic                w_any;
   logic                w_xfer;
   logic [1:0]          w_sel_oh;
   logic [ADDR_W-1:0]   w_addr_mux;
   logic [LEN_W-1:0]    w_len_mux;
   logic [DATA_W-1:0]   w_wdata_mux;

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .last (r_last),
      .sel  (w_sel),
      .any  (w_any)
   );

   // Candidate request fields, steered by the arbiter's live choice
   assign w_addr_mux  = w_sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign w_len_mux   = w_sel ? len[2*LEN_W-1:LEN_W]    : len[LEN_W-1:0];
   // Write data always comes from the latched owner of the burst
   assign w_wdata_mux = r_sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next = XFER;
         XFER:    if (r_cnt == '0) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // Request fields are sampled only in IDLE, so anything the requester
   // changes during the burst has no effect until the next arbitration.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         r_sel      <= 1'b0;
         r_last     <= 1'b1;   // requester 0 wins the first contention
         r_rw       <= 1'b0;
         r_first    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_addr     <= '0;
         r_cnt      <= '0;
         r_rd_data  <= '0;
      end else begin
         r_first    <= 1'b0;
         r_rd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_sel   <= w_sel;
                  r_rw    <= w_sel ? rw[1] : rw[0];
                  r_addr  <= w_addr_mux;
                  r_cnt   <= w_len_mux;
                  r_first <= 1'b1;
               end
            end
            XFER: begin
               // Natural unsigned overflow gives the address wrap to 0
               r_addr <= r_addr + 1'b1;
               r_cnt  <= r_cnt - 1'b1;
               if (!r_rw) begin
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= ram_data_out;
               end
            end
            DONE: begin
               r_last <= r_sel;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ outputs
   assign w_xfer      = (r_state == XFER);
   assign w_sel_oh    = r_sel ? 2'b10 : 2'b01;

   assign gnt         = (w_xfer && r_first) ? w_sel_oh : 2'b00;
   assign ram_wren    = w_xfer && r_rw;
   assign wr_ack      = ram_wren ? w_sel_oh : 2'b00;
   assign ram_address = w_xfer ? r_addr : '0;
   assign ram_data_in = ram_wren ? w_wdata_mux : '0;
   assign rd_valid    = r_rd_valid ? w_sel_oh : 2'b00;
   assign rd_data     = r_rd_data;
   assign done        = (r_state == DONE) ? w_sel_oh : 2'b00;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a small
//               behavioural RAM attached to the RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;

   logic                clock;
   logic                rstn;
   logic [1:0]          req;
   logic [1:0]          rw;
   logic [2*ADDR_W-1:0] addr;
   logic [2*LEN_W-1:0]  len;
   logic [2*DATA_W-1:0] wdata;
   logic [1:0]          gnt;
   logic [1:0]          wr_ack;
   logic [1:0]          rd_valid;
   logic [DATA_W-1:0]   rd_data;
   logic [1:0]          done;
   logic [ADDR_W-1:0]   ram_address;
   logic [DATA_W-1:0]   ram_data_in;
   logic                ram_wren;
   logic [DATA_W-1:0]   ram_data_out;

   int n_total;
   int n_bad;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   ram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_dut (
      .clock        (clock),
      .rstn         (rstn),
      .req          (req),
      .rw           (rw),
      .addr         (addr),
      .len          (len),
      .wdata        (wdata),
      .gnt          (gnt),
      .wr_ack       (wr_ack),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .done         (done),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_wren     (ram_wren),
      .ram_data_out (ram_data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // External RAM: synchronous write, combinational read
   always @(posedge clock) begin
      if (ram_wren) mem[ram_address] <= ram_data_in;
   end
   assign ram_data_out = mem[ram_address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive point: just after the active edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Sample point: opposite edge
   task automatic mid();
      @(negedge clock);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
      req   = 2'b00;
      rw    = 2'b00;
      addr  = '0;
      len   = '0;
      wdata = '0;
      rstn  = 1'b0;

      // ---------------- reset state
      #2;
      chk("rst_gnt",   32'(gnt),         32'h0);
      chk("rst_wren",  32'(ram_wren),    32'h0);
      chk("rst_addr",  32'(ram_address), 32'h0);
      chk("rst_done",  32'(done),        32'h0);
      chk("rst_rdv",   32'(rd_valid),    32'h0);
      chk("rst_rdata", 32'(rd_data),     32'h0);
      step();
      step();
      rstn = 1'b1;
      step();

      // ---------------- 4-beat write from requester 0 at 0x010
      req = 2'b01; rw = 2'b01; addr[11:0] = 12'h010; len[3:0] = 4'd3;
      wdata[7:0] = 8'hA1;
      step();
      req = 2'b00;
      for (int b = 0; b < 4; b++) begin
         wdata[7:0] = 8'(8'hA1 + b);
         mid();
         chk("wr_gnt",  32'(gnt),         (b == 0) ? 32'h1 : 32'h0);
         chk("wr_wren", 32'(ram_wren),    32'h1);
         chk("wr_addr", 32'(ram_address), 32'h010 + b);
         chk("wr_data", 32'(ram_data_in), 32'hA1 + b);
         chk("wr_ack",  32'(wr_ack),      32'h1);
         chk("wr_done", 32'(done),        32'h0);
         step();
      end
      mid();
      chk("wr_done_pulse", 32'(done),     32'h1);
      chk("wr_done_wren",  32'(ram_wren), 32'h0);
      step();
      mid();
      chk("wr_idle_done", 32'(done), 32'h0);

      // ---------------- 4-beat read-back from requester 0
      step();
      req = 2'b01; rw = 2'b00; addr[11:0] = 12'h010; len[3:0] = 4'd3;
      step();
      req = 2'b00;
      for (int b = 0; b < 4; b++) begin
         mid();
         chk("rd_gnt",  32'(gnt),      (b == 0) ? 32'h1 : 32'h0);
         chk("rd_wren", 32'(ram_wren), 32'h0);
         if (b == 0) begin
            chk("rd_valid0", 32'(rd_valid), 32'h0);
         end else begin
            chk("rd_valid", 32'(rd_valid), 32'h1);
            chk("rd_data",  32'(rd_data),  32'hA1 + b - 1);
         end
         step();
      end
      mid();
      chk("rd_last_valid", 32'(rd_valid), 32'h1);
      chk("rd_last_data",  32'(rd_data),  32'hA4);
      chk("rd_done",       32'(done),     32'h1);
      step();
      mid();
      chk("rd_idle_valid", 32'(rd_valid), 32'h0);

      // ---------------- round-robin from fresh reset, both held high
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      step();
      req = 2'b11; rw = 2'b00; len = '0;
      addr[11:0] = 12'h010; addr[23:12] = 12'h011;
      step();
      for (int t = 0; t < 4; t++) begin
         mid();
         chk("rr_gnt",  32'(gnt),  (t % 2 == 0) ? 32'h1 : 32'h2);
         step();
         mid();
         chk("rr_done", 32'(done), (t % 2 == 0) ? 32'h1 : 32'h2);
         step();
         mid();
         chk("rr_idle", 32'(gnt),  32'h0);
         step();
      end
      req = 2'b00;
      step();
      step();

      // ---------------- address wrap on requester 1
      req = 2'b10; rw = 2'b10; addr[23:12] = 12'hFFE; len[7:4] = 4'd3;
      wdata[15:8] = 8'h55;
      step();
      req = 2'b00;
      for (int b = 0; b < 4; b++) begin
         logic [11:0] exp_a;
         exp_a = 12'hFFE + 12'(b);
         mid();
         chk("wrap_addr",  32'(ram_address), 32'(exp_a));
         chk("wrap_ack",   32'(wr_ack),      32'h2);
         step();
      end
      mid();
      chk("wrap_done", 32'(done), 32'h2);
      step();
      step();

      // ---------------- reset during 2nd beat of a 16-beat write
      req = 2'b01; rw = 2'b01; addr[11:0] = 12'h100; len[3:0] = 4'd15;
      wdata[7:0] = 8'h77;
      step();
      req = 2'b00;
      step();
      chk("abort_pre_wren", 32'(ram_wren), 32'h1);
      rstn = 1'b0;
      #1;
      chk("abort_wren",  32'(ram_wren),    32'h0);
      chk("abort_addr",  32'(ram_address), 32'h0);
      chk("abort_ack",   32'(wr_ack),      32'h0);
      chk("abort_done",  32'(done),        32'h0);
      chk("abort_rdata", 32'(rd_data),     32'h0);
      req = 2'b10; rw = 2'b00; len[7:4] = 4'd0;
      for (int c = 0; c < 3; c++) begin
         mid();
         chk("abort_no_done", 32'(done), 32'h0);
      end
      rstn = 1'b1;
      step();
      mid();
      chk("post_rst_gnt1", 32'(gnt), 32'h2);
      req = 2'b01; rw = 2'b00; len[3:0] = 4'd0;
      step();
      mid();
      chk("post_rst_done1", 32'(done), 32'h2);
      step();
      step();
      mid();
      chk("post_rst_gnt0", 32'(gnt), 32'h1);
      req = 2'b00;
      step();
      step();

      // ---------------- inputs changed after grant are ignored
      req = 2'b01; rw = 2'b01; addr[11:0] = 12'h200; len[3:0] = 4'd2;
      step();
      req = 2'b00; rw = 2'b00; addr[11:0] = 12'h3AA; len[3:0] = 4'd0;
      for (int b = 0; b < 3; b++) begin
         wdata[7:0] = 8'(8'h30 + b);
         mid();
         chk("hold_wren", 32'(ram_wren),    32'h1);
         chk("hold_addr", 32'(ram_address), 32'h200 + b);
         chk("hold_data", 32'(ram_data_in), 32'h30 + b);
         chk("hold_done", 32'(done),        32'h0);
         step();
      end
      mid();
      chk("hold_done_pulse", 32'(done), 32'h1);
      step();
      mid();
      chk("hold_idle_gnt", 32'(gnt), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_ram_arbiter
`default_nettype wire
